// File: rtl/a2d_pkg.sv
// Shared types and command framing for the A2D scan controller.
// Imported by the SPI shifter and the scan sequencer.
package a2d_pkg;

  typedef enum logic [1:0] {
    MODE_SINGLE = 2'd0,
    MODE_SCAN   = 2'd1,
    MODE_CONT   = 2'd2
  } mode_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_GAP,
    ST_RD,
    ST_PIPE
  } state_t;

  localparam int          A2D_BITS       = 16;
  localparam logic [1:0]  A2D_CMD_PAD_HI = 2'b00;
  localparam logic [10:0] A2D_CMD_PAD_LO = 11'h000;

  function automatic logic [15:0] a2d_cmd(input logic [2:0] ch);
    return {A2D_CMD_PAD_HI, ch, A2D_CMD_PAD_LO};
  endfunction

endpackage

// File: rtl/a2d_spi_xfer.sv
// 16-bit SPI master: SS_n framing, SCLK divider, MOSI on fall, MISO on rise.
// Keeps only the last DATA_W received bits, so upper bits fall away.
module a2d_spi_xfer
  import a2d_pkg::*;
#(
  parameter int SCLK_DIV = 5,
  parameter int DATA_W   = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wrt,
  input  logic [15:0]       cmd,
  output logic [DATA_W-1:0] rd_data,
  output logic              done,
  output logic              SS_n,
  output logic              SCLK,
  output logic              MOSI,
  input  logic              MISO
);

  typedef enum logic [1:0] {X_IDLE, X_SHIFT, X_TAIL} xst_t;

  localparam logic [SCLK_DIV-1:0] CNT_MAX  = '1;
  localparam logic [SCLK_DIV-1:0] CNT_FALL = CNT_MAX >> 1;
  localparam logic [4:0]          BIT_LAST = 5'(A2D_BITS - 1);

  xst_t                st_q, st_d;
  logic [SCLK_DIV-1:0] cnt_q, cnt_d;
  logic [4:0]          bits_q, bits_d;
  logic [15:0]         tx_q, tx_d;
  logic [DATA_W-1:0]   rx_q, rx_d;
  logic                ss_n_q, ss_n_d;
  logic                sclk_q, sclk_d;
  logic                done_q, done_d;

  // state and shift registers
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q   <= X_IDLE;
      cnt_q  <= '0;
      bits_q <= '0;
      tx_q   <= '0;
      rx_q   <= '0;
      ss_n_q <= 1'b1;
      sclk_q <= 1'b1;
      done_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      bits_q <= bits_d;
      tx_q   <= tx_d;
      rx_q   <= rx_d;
      ss_n_q <= ss_n_d;
      sclk_q <= sclk_d;
      done_q <= done_d;
    end
  end

  // first SCLK fall is skipped so the MSB is seen on the first rise
  always_comb begin
    st_d   = st_q;
    cnt_d  = cnt_q;
    bits_d = bits_q;
    tx_d   = tx_q;
    rx_d   = rx_q;
    ss_n_d = ss_n_q;
    sclk_d = sclk_q;
    done_d = 1'b0;
    unique case (st_q)
      X_IDLE: begin
        if (wrt) begin
          st_d   = X_SHIFT;
          cnt_d  = '0;
          bits_d = '0;
          tx_d   = cmd;
          ss_n_d = 1'b0;
          sclk_d = 1'b1;
        end
      end
      X_SHIFT: begin
        cnt_d  = cnt_q + 1'b1;
        sclk_d = ~cnt_d[SCLK_DIV-1];
        if (cnt_q == CNT_FALL && bits_q != '0)
          tx_d = {tx_q[14:0], 1'b0};
        if (cnt_q == CNT_MAX) begin
          rx_d   = {rx_q[DATA_W-2:0], MISO};
          bits_d = bits_q + 1'b1;
          if (bits_q == BIT_LAST)
            st_d = X_TAIL;
        end
      end
      X_TAIL: begin
        st_d   = X_IDLE;
        ss_n_d = 1'b1;
        done_d = 1'b1;
      end
      default: st_d = X_IDLE;
    endcase
  end

  assign rd_data = rx_q;
  assign done    = done_q;
  assign SS_n    = ss_n_q;
  assign SCLK    = sclk_q;
  assign MOSI    = ~ss_n_q & tx_q[15];

endmodule

// File: rtl/a2d_scan_ctrl.sv
// Scan sequencer for the SPI A/D: single-step, full-scan, continuous.
// Scan modes pipeline commands: txn k sends slot k, returns slot k-1.
module a2d_scan_ctrl
  import a2d_pkg::*;
#(
  parameter int                  NUM_CH   = 3,
  parameter logic [NUM_CH*3-1:0] CH_MAP   = {3'd5, 3'd4, 3'd0},
  parameter int                  DATA_W   = 12,
  parameter int                  SCLK_DIV = 5,
  parameter int                  GAP_CYC  = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [1:0]               mode,
  input  logic                     start,
  input  logic                     stop,
  output logic                     busy,
  output logic [NUM_CH*DATA_W-1:0] result,
  output logic [NUM_CH-1:0]        res_vld,
  output logic                     smpl_done,
  output logic [2:0]               smpl_slot,
  output logic                     scan_done,
  output logic                     SS_n_A2D,
  output logic                     SCLK_A2D,
  output logic                     MOSI_A2D,
  input  logic                     MISO_A2D
);

  localparam int              GW        = $clog2(GAP_CYC + 1);
  localparam logic [GW-1:0]   GAP_LAST  = GW'(GAP_CYC - 1);
  localparam logic [2:0]      SLOT_LAST = 3'(NUM_CH - 1);
  localparam logic [3:0]      TXN_LAST  = 4'(NUM_CH);

  state_t                    st_q, st_d;
  mode_e                     mode_q, mode_d, req_mode;
  logic [2:0]                rr_q, rr_d;
  logic [3:0]                txn_q, txn_d;
  logic [GW-1:0]             gap_q, gap_d;
  logic                      stop_q, stop_d;
  logic [NUM_CH*DATA_W-1:0]  result_q, result_d;
  logic [NUM_CH-1:0]         res_vld_q, res_vld_d;
  logic                      smpl_done_q, smpl_done_d;
  logic [2:0]                smpl_slot_q, smpl_slot_d;
  logic                      scan_done_q, scan_done_d;

  logic                      wrt, xfer_done, wr_en;
  logic [2:0]                snd_slot, wr_slot, cmd_ch;
  logic [15:0]               cmd;
  logic [DATA_W-1:0]         rd_data;

  a2d_spi_xfer #(
    .SCLK_DIV (SCLK_DIV),
    .DATA_W   (DATA_W)
  ) u_spi (
    .clk     (clk),
    .rst     (rst),
    .wrt     (wrt),
    .cmd     (cmd),
    .rd_data (rd_data),
    .done    (xfer_done),
    .SS_n    (SS_n_A2D),
    .SCLK    (SCLK_A2D),
    .MOSI    (MOSI_A2D),
    .MISO    (MISO_A2D)
  );

  // sequencer state, counters and result holding registers
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q        <= ST_IDLE;
      mode_q      <= MODE_SINGLE;
      rr_q        <= '0;
      txn_q       <= '0;
      gap_q       <= '0;
      stop_q      <= 1'b0;
      result_q    <= '0;
      res_vld_q   <= '0;
      smpl_done_q <= 1'b0;
      smpl_slot_q <= '0;
      scan_done_q <= 1'b0;
    end else begin
      st_q        <= st_d;
      mode_q      <= mode_d;
      rr_q        <= rr_d;
      txn_q       <= txn_d;
      gap_q       <= gap_d;
      stop_q      <= stop_d;
      result_q    <= result_d;
      res_vld_q   <= res_vld_d;
      smpl_done_q <= smpl_done_d;
      smpl_slot_q <= smpl_slot_d;
      scan_done_q <= scan_done_d;
    end
  end

  // next state, command issue and slot writes
  always_comb begin
    st_d        = st_q;
    mode_d      = mode_q;
    rr_d        = rr_q;
    txn_d       = txn_q;
    gap_d       = gap_q;
    stop_d      = stop_q;
    result_d    = result_q;
    res_vld_d   = res_vld_q;
    smpl_done_d = 1'b0;
    smpl_slot_d = smpl_slot_q;
    scan_done_d = 1'b0;
    wrt         = 1'b0;
    snd_slot    = '0;
    wr_en       = 1'b0;
    wr_slot     = '0;
    cmd_ch      = '0;

    case (mode)
      2'd1:    req_mode = MODE_SCAN;
      2'd2:    req_mode = MODE_CONT;
      default: req_mode = MODE_SINGLE;
    endcase

    // stop is only remembered while a run is in progress
    if (st_q != ST_IDLE && stop)
      stop_d = 1'b1;

    unique case (st_q)
      ST_IDLE: begin
        if (start) begin
          mode_d = req_mode;
          stop_d = 1'b0;
          txn_d  = '0;
          wrt    = 1'b1;
          if (req_mode == MODE_SINGLE) begin
            snd_slot = rr_q;
            st_d     = ST_CMD;
          end else begin
            st_d = ST_PIPE;
          end
        end
      end
      ST_CMD: begin
        if (xfer_done) begin
          gap_d = '0;
          st_d  = ST_GAP;
        end
      end
      ST_GAP: begin
        gap_d = gap_q + 1'b1;
        if (gap_q == GAP_LAST) begin
          wrt = 1'b1;
          if (mode_q == MODE_SINGLE) begin
            snd_slot = rr_q;
            st_d     = ST_RD;
          end else begin
            snd_slot = (txn_q >= TXN_LAST) ? SLOT_LAST : txn_q[2:0];
            st_d     = ST_PIPE;
          end
        end
      end
      ST_RD: begin
        if (xfer_done) begin
          wr_en   = 1'b1;
          wr_slot = rr_q;
          rr_d    = (rr_q == SLOT_LAST) ? 3'd0 : rr_q + 3'd1;
          st_d    = ST_IDLE;
        end
      end
      ST_PIPE: begin
        if (xfer_done) begin
          gap_d = '0;
          st_d  = ST_GAP;
          txn_d = txn_q + 4'd1;
          if (txn_q != 4'd0) begin
            wr_en   = 1'b1;
            wr_slot = 3'(txn_q - 4'd1);
          end
          if (txn_q == TXN_LAST) begin
            scan_done_d = 1'b1;
            txn_d       = '0;
            if (mode_q != MODE_CONT || stop_q)
              st_d = ST_IDLE;
          end
        end
      end
      default: st_d = ST_IDLE;
    endcase

    for (int i = 0; i < NUM_CH; i++) begin
      if (snd_slot == 3'(i))
        cmd_ch = CH_MAP[i*3 +: 3];
      if (wr_en && wr_slot == 3'(i)) begin
        result_d[i*DATA_W +: DATA_W] = rd_data;
        res_vld_d[i]                 = 1'b1;
      end
    end

    if (wr_en) begin
      smpl_done_d = 1'b1;
      smpl_slot_d = wr_slot;
    end
  end

  assign cmd       = a2d_cmd(cmd_ch);
  assign busy      = (st_q != ST_IDLE);
  assign result    = result_q;
  assign res_vld   = res_vld_q;
  assign smpl_done = smpl_done_q;
  assign smpl_slot = smpl_slot_q;
  assign scan_done = scan_done_q;

endmodule
